sram_rw_ctrl: RTL and testbench
===============================

SRAM_RW_CTRL -- requirements
Module: sram_rw_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning SRAM address width (1024 entries).
REQ-002 SHALL have parameter DATA_W, default 2112, meaning SRAM row width in bits.
REQ-003 SHALL have parameter MASK_W, default 16, meaning write-mask lanes; lane width DATA_W/MASK_W (132).
REQ-004 SHALL have port clock, input, 1, meaning the single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port rd_valid/rd_ready, input/output, 1/1, meaning read request handshake; rd_addr, input, ADDR_W.
REQ-007 SHALL have port wr_valid/wr_ready, input/output, 1/1, meaning write request handshake; wr_addr, input, ADDR_W; wr_mask, input, MASK_W; wr_data, input, DATA_W.
REQ-008 SHALL have port resp_valid/resp_ready, output/input, 1/1, meaning read response handshake; resp_data, output, DATA_W.
REQ-009 SHALL have port sram_en, sram_wmode, output, 1 each; sram_addr, output, ADDR_W; sram_wmask, output, MASK_W; sram_wdata, output, DATA_W; meaning single-port SRAM command.
REQ-010 SHALL have port sram_rdata, input, DATA_W, meaning SRAM read data, valid the cycle after a read command.
REQ-011 SHALL have port init_done, output, 1, meaning array initialised and requests accepted.

Function
REQ-012 SHALL issue at most one SRAM command per cycle; a request transfers when valid and ready are both high in the same cycle.
REQ-013 SHALL drive sram_en=1 exactly in cycles where a read or write transfers (or an init write occurs); sram_wmode=1 for writes, 0 for reads; all sram_* outputs combinational from the granted request.
REQ-014 SHALL arbitrate round-robin when rd_valid and wr_valid are both high: grant the class not granted last; after reset read has priority.
REQ-015 SHALL hold rd_ready=0 unless (buffered responses + reads in flight) < 2.
REQ-016 SHALL capture sram_rdata into a 2-entry response FIFO at the end of the cycle after the read transfer; read accepted in cycle N gives resp_valid earliest in cycle N+2.
REQ-017 SHALL return responses in request order; resp_data stable while resp_valid=1 and resp_ready=0.
REQ-018 SHALL make a read of an address written in an earlier cycle return the written lanes; unmasked lanes unchanged.
REQ-019 SHALL use state machine S_INIT -> S_RUN; S_RUN is terminal until reset.
REQ-020 SHALL, in S_INIT, write all-zero data with all mask bits set to addresses 0..2^ADDR_W-1, one per cycle, then enter S_RUN; rd_ready=wr_ready=0 throughout.
REQ-021 SHALL assert init_done only in S_RUN.

Reset
REQ-022 SHALL, while reset=1, drive rd_ready=0, wr_ready=0, resp_valid=0, sram_en=0, init_done=0, init address 0, FIFO empty, in-flight flag 0, round-robin pointer to read.
REQ-023 SHALL discard buffered and in-flight responses on reset; reset mid-init restarts the sweep at address 0.

Configuration
REQ-024 SHALL implement S_INIT only when macro SRAM_RW_CTRL_INIT_EN is defined; without it, the block enters S_RUN directly after reset (init_done=1 from the first cycle after reset deasserts) and no init writes occur.

Structure
REQ-025 SHALL place ADDR_W/DATA_W/MASK_W defaults and the state enum (S_INIT, S_RUN) in shared package sram_rw_ctrl_pkg.
REQ-026 SHALL implement the response FIFO as sub-module sram_resp_fifo (depth 2, valid/ready both sides).

Verification
REQ-027 SHALL test: write addr 0x005 mask 0xFFFF data pattern A, then read 0x005 -> resp_data=A exactly 2 cycles after read transfer.
REQ-028 SHALL test: write 0x010 all-ones mask 0xFFFF, then write 0x010 zeros mask 0x0001, read -> lane 0 zero, lanes 1-15 all-ones.
REQ-029 SHALL test: resp_ready=0, issue 3 reads -> 2 accepted, rd_ready low on third until one response pops; order preserved.
REQ-030 SHALL test: rd_valid and wr_valid high 4 cycles -> grants alternate R,W,R,W.
REQ-031 SHALL test with SRAM_RW_CTRL_INIT_EN: init_done rises 1024 cycles after reset release; read of 0x3FF -> 0; reset asserted at sweep address 200 -> sweep restarts at 0.
REQ-032 SHALL test: reset asserted with one read in flight and one buffered -> no resp_valid after reset release.

Source files
------------

// File: rtl/sram_rw_ctrl_pkg.sv
// rtl/sram_rw_ctrl_pkg.sv - shared defaults, state enum and occupancy helper for sram_rw_ctrl
package sram_rw_ctrl_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 2112;
    localparam int MASK_W_DEF = 16;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Reads that already own a response slot: buffered plus the one on the SRAM bus.
    function automatic logic [1:0] occupancy(input logic [1:0] count, input logic inflight);
        return count + {1'b0, inflight};
    endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// rtl/sram_resp_fifo.sv - 2-entry read response FIFO with valid/ready on both sides
module sram_resp_fifo
    import sram_rw_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_push_valid,
    output logic              o_push_ready,
    input  logic [DATA_W-1:0] i_push_data,
    output logic              o_pop_valid,
    input  logic              i_pop_ready,
    output logic [DATA_W-1:0] o_pop_data,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    assign o_push_ready = (r_count != 2'd2);
    assign o_pop_valid  = (r_count != 2'd0);
    assign o_pop_data   = r_mem[r_rd_ptr];
    assign o_count      = r_count;
    assign w_push       = i_push_valid && o_push_ready;
    assign w_pop        = o_pop_valid && i_pop_ready;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_rw_ctrl.sv
// rtl/sram_rw_ctrl.sv - single-port SRAM read/write arbiter with in-order responses
// Optional zero-fill sweep after reset when SRAM_RW_CTRL_INIT_EN is defined.
module sram_rw_ctrl
    import sram_rw_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int MASK_W = MASK_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [MASK_W-1:0] wr_mask,
    input  logic [DATA_W-1:0] wr_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              init_done
);

`ifdef SRAM_RW_CTRL_INIT_EN
    localparam state_t            RESET_STATE = S_INIT;
    localparam logic [ADDR_W-1:0] INIT_LAST   = {ADDR_W{1'b1}};
    logic [ADDR_W-1:0] r_init_addr;
    logic              w_init_wr;
`else
    localparam state_t RESET_STATE = S_RUN;
`endif

    state_t     r_state;
    state_t     w_state_next;
    logic       r_wr_turn;
    logic       r_rd_inflight;
    logic [1:0] w_fifo_count;
    logic       w_fifo_in_ready;
    logic       w_fifo_out_valid;
    logic       w_rd_space;
    logic       w_rd_xfer;
    logic       w_wr_xfer;

    // A read is only accepted when its response is guaranteed a FIFO slot.
    assign w_rd_space = w_fifo_in_ready && (occupancy(w_fifo_count, r_rd_inflight) < 2'd2);

    always_comb begin
        w_state_next = r_state;
        rd_ready     = 1'b0;
        wr_ready     = 1'b0;
        init_done    = 1'b0;
        sram_en      = 1'b0;
        sram_wmode   = 1'b0;
        sram_addr    = '0;
        sram_wmask   = '0;
        sram_wdata   = '0;
`ifdef SRAM_RW_CTRL_INIT_EN
        w_init_wr    = 1'b0;
`endif
        if (!reset) begin
            case (r_state)
`ifdef SRAM_RW_CTRL_INIT_EN
                S_INIT: begin
                    w_init_wr  = 1'b1;
                    sram_en    = 1'b1;
                    sram_wmode = 1'b1;
                    sram_addr  = r_init_addr;
                    sram_wmask = '1;
                    if (r_init_addr == INIT_LAST) begin
                        w_state_next = S_RUN;
                    end
                end
`endif
                S_RUN: begin
                    init_done = 1'b1;
                    rd_ready  = w_rd_space && !(wr_valid && r_wr_turn);
                    wr_ready  = !(rd_valid && w_rd_space && !r_wr_turn);
                end
                default: ;
            endcase
        end
        w_rd_xfer = rd_valid && rd_ready;
        w_wr_xfer = wr_valid && wr_ready && !w_rd_xfer;
        if (w_rd_xfer) begin
            sram_en   = 1'b1;
            sram_addr = rd_addr;
        end else if (w_wr_xfer) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = wr_addr;
            sram_wmask = wr_mask;
            sram_wdata = wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= RESET_STATE;
            r_wr_turn     <= 1'b0;
            r_rd_inflight <= 1'b0;
`ifdef SRAM_RW_CTRL_INIT_EN
            r_init_addr   <= '0;
`endif
        end else begin
            r_state       <= w_state_next;
            r_rd_inflight <= w_rd_xfer;
            if (w_rd_xfer) begin
                r_wr_turn <= 1'b1;
            end else if (w_wr_xfer) begin
                r_wr_turn <= 1'b0;
            end
`ifdef SRAM_RW_CTRL_INIT_EN
            if (w_init_wr) begin
                r_init_addr <= r_init_addr + 1'b1;
            end
`endif
        end
    end

    sram_resp_fifo #(
        .DATA_W(DATA_W)
    ) u_resp_fifo (
        .clock        (clock),
        .reset        (reset),
        .i_push_valid (r_rd_inflight),
        .o_push_ready (w_fifo_in_ready),
        .i_push_data  (sram_rdata),
        .o_pop_valid  (w_fifo_out_valid),
        .i_pop_ready  (resp_ready),
        .o_pop_data   (resp_data),
        .o_count      (w_fifo_count)
    );

    assign resp_valid = w_fifo_out_valid && !reset;

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// tb/tb_sram_rw_ctrl.sv - randomized self-checking bench for sram_rw_ctrl with behavioural memory model
module tb_sram_rw_ctrl;

    localparam int AW = 10;
    localparam int DW = 2112;
    localparam int MW = 16;
    localparam int LW = DW / MW;

    logic          clock;
    logic          reset;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [MW-1:0] wr_mask;
    logic [DW-1:0] wr_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          sram_en;
    logic          sram_wmode;
    logic [AW-1:0] sram_addr;
    logic [MW-1:0] sram_wmask;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic          init_done;

    int total;
    int bad;

    sram_rw_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
        .clock(clock), .reset(reset),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_mask(wr_mask), .wr_data(wr_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .init_done(init_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [DW-1:0] rand_row();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [DW-1:0] lane_bits(input logic [MW-1:0] m);
        logic [DW-1:0] r;
        for (int l = 0; l < MW; l++) r[l*LW +: LW] = {LW{m[l]}};
        return r;
    endfunction

    // Handshakes and SRAM command sampled mid-cycle, well away from the rising edge.
    logic          p_reset, p_rd_xfer, p_wr_xfer, p_pop, p_en, p_wmode;
    logic [AW-1:0] p_rd_addr, p_wr_addr, p_addr;
    logic [MW-1:0] p_wr_mask, p_wmask;
    logic [DW-1:0] p_wr_data, p_wdata;

    always @(negedge clock) begin
        #3;
        p_reset   = reset;
        p_rd_xfer = rd_valid && rd_ready;
        p_rd_addr = rd_addr;
        p_wr_xfer = wr_valid && wr_ready;
        p_wr_addr = wr_addr;
        p_wr_mask = wr_mask;
        p_wr_data = wr_data;
        p_pop     = resp_valid && resp_ready;
        p_en      = sram_en;
        p_wmode   = sram_wmode;
        p_addr    = sram_addr;
        p_wmask   = sram_wmask;
        p_wdata   = sram_wdata;
    end

    logic [DW-1:0] sram_mem [1024];

    always @(posedge clock) begin
        if (p_en) begin
            if (p_wmode) begin
                for (int l = 0; l < MW; l++)
                    if (p_wmask[l]) sram_mem[p_addr][l*LW +: LW] <= p_wdata[l*LW +: LW];
            end else begin
                sram_rdata <= sram_mem[p_addr];
            end
        end
    end

    // Reference: what every address should hold, and the responses still owed in order.
    logic [DW-1:0] mdl_mem [1024];
    logic [DW-1:0] exp_q [$];

    always @(posedge clock) begin
        if (p_reset) begin
            exp_q.delete();
`ifdef SRAM_RW_CTRL_INIT_EN
            for (int a = 0; a < 1024; a++) mdl_mem[a] = '0;
`endif
        end else begin
            if (p_pop && exp_q.size() > 0) void'(exp_q.pop_front());
            if (p_rd_xfer) exp_q.push_back(mdl_mem[p_rd_addr]);
            if (p_wr_xfer)
                mdl_mem[p_wr_addr] = (mdl_mem[p_wr_addr] & ~lane_bits(p_wr_mask)) |
                                     (p_wr_data & lane_bits(p_wr_mask));
        end
    end

    task automatic wait_init(output int n);
        n = 0;
`ifdef SRAM_RW_CTRL_INIT_EN
        for (n = 0; n < 1100; n++) begin
            #1;
            if (init_done) break;
            @(negedge clock);
        end
        total++;
        if (n >= 1100) begin
            bad++;
            $display("FAIL init_timeout: init_done still %b after %0d cycles", init_done, n);
        end
`endif
    endtask

    task automatic do_reset();
        int n;
        @(negedge clock);
        reset = 1'b1; rd_valid = 1'b0; wr_valid = 1'b0; resp_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        wait_init(n);
    endtask

    task automatic wr_one(input logic [AW-1:0] a, input logic [MW-1:0] m, input logic [DW-1:0] d);
        bit ok;
        ok = 1'b0;
        @(negedge clock);
        wr_valid = 1'b1; wr_addr = a; wr_mask = m; wr_data = d;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (wr_ready) begin ok = 1'b1; break; end
            @(negedge clock);
        end
        @(negedge clock);
        wr_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wr_accept addr %h: wr_ready got 0 want 1", a);
        end
    endtask

    task automatic test_reset();
        int n;
        @(negedge clock);
        reset = 1'b1; rd_valid = 1'b1; wr_valid = 1'b1; rd_addr = 'h5; wr_addr = 'h6; resp_ready = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        total += 5;
        if (rd_ready !== 1'b0)   begin bad++; $display("FAIL rst_rd_ready: got %b want 0", rd_ready); end
        if (wr_ready !== 1'b0)   begin bad++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        if (sram_en !== 1'b0)    begin bad++; $display("FAIL rst_sram_en: got %b want 0", sram_en); end
        if (init_done !== 1'b0)  begin bad++; $display("FAIL rst_init_done: got %b want 0", init_done); end
        rd_valid = 1'b0; wr_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        total += 2;
`ifdef SRAM_RW_CTRL_INIT_EN
        if (init_done !== 1'b0) begin bad++; $display("FAIL rel_init_done: got %b want 0", init_done); end
        if (!(sram_en === 1'b1 && sram_addr === '0)) begin
            bad++; $display("FAIL rel_sweep_start: en %b addr %h want en 1 addr 0", sram_en, sram_addr);
        end
        wait_init(n);
`else
        if (init_done !== 1'b1) begin bad++; $display("FAIL rel_init_done: got %b want 1", init_done); end
        if (sram_en !== 1'b0)   begin bad++; $display("FAIL rel_no_init_wr: sram_en got %b want 0", sram_en); end
        n = 0;
`endif
    endtask

    task automatic test_write_read();
        logic [DW-1:0] a;
        a = rand_row();
        resp_ready = 1'b1;
        @(negedge clock);
        wr_valid = 1'b1; wr_addr = 'h005; wr_mask = 16'hFFFF; wr_data = a;
        #1;
        total++;
        if (!(wr_ready === 1'b1 && sram_en === 1'b1 && sram_wmode === 1'b1 && sram_addr === 10'h005)) begin
            bad++;
            $display("FAIL wr_cmd: ready %b en %b wmode %b addr %h want 1 1 1 005", wr_ready, sram_en, sram_wmode, sram_addr);
        end
        @(negedge clock);
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 'h005;
        #1;
        total++;
        if (!(rd_ready === 1'b1 && sram_en === 1'b1 && sram_wmode === 1'b0)) begin
            bad++; $display("FAIL rd_cmd: ready %b en %b wmode %b want 1 1 0", rd_ready, sram_en, sram_wmode);
        end
        @(negedge clock);
        rd_valid = 1'b0;
        #1;
        total++;
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL rd_lat_n1: resp_valid got %b want 0", resp_valid); end
        @(negedge clock);
        #1;
        total += 2;
        if (resp_valid !== 1'b1) begin bad++; $display("FAIL rd_lat_n2: resp_valid got %b want 1", resp_valid); end
        if (resp_data !== a) begin
            bad++; $display("FAIL rd_data: got %h want %h (low 64b)", resp_data[63:0], a[63:0]);
        end
    endtask

    task automatic test_mask();
        logic [DW-1:0] e;
        bit seen;
        e = '1;
        e[LW-1:0] = '0;
        seen = 1'b0;
        resp_ready = 1'b1;
        wr_one('h010, 16'hFFFF, '1);
        wr_one('h010, 16'h0001, '0);
        @(negedge clock);
        rd_valid = 1'b1; rd_addr = 'h010;
        @(negedge clock);
        rd_valid = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            #1;
            if (resp_valid) begin
                seen = 1'b1;
                total++;
                if (resp_data !== e) begin
                    bad++;
                    $display("FAIL mask_merge: lane0 %h lane1 low %h want lane0 0 lane1 ones",
                             resp_data[63:0], resp_data[LW +: 32]);
                end
            end
            @(negedge clock);
        end
        total++;
        if (!seen) begin bad++; $display("FAIL mask_resp: no response got 0 want 1"); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d [3];
        logic [DW-1:0] got [$];
        int acc;
        for (int i = 0; i < 3; i++) begin
            d[i] = rand_row();
            wr_one(AW'(10'h030 + i), 16'hFFFF, d[i]);
        end
        resp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            rd_valid = 1'b1; rd_addr = AW'(10'h030 + acc);
            #1;
            if (rd_ready) acc++;
        end
        total += 4;
        if (acc !== 2) begin bad++; $display("FAIL bp_accepted: got %0d want 2", acc); end
        if (rd_ready !== 1'b0) begin bad++; $display("FAIL bp_rd_ready: got %b want 0", rd_ready); end
        if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_resp_valid: got %b want 1", resp_valid); end
        if (resp_data !== d[0]) begin bad++; $display("FAIL bp_head: got %h want %h", resp_data[63:0], d[0][63:0]); end
        @(negedge clock);
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        #1;
        total++;
        if (rd_ready !== 1'b1) begin bad++; $display("FAIL bp_reopen: rd_ready got %b want 1", rd_ready); end
        @(negedge clock);
        rd_valid = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (resp_valid) got.push_back(resp_data);
            @(negedge clock);
        end
        total++;
        if (got.size() !== 2) begin
            bad++; $display("FAIL bp_count: got %0d responses want 2", got.size());
        end else begin
            total++;
            if (got[0] !== d[1] || got[1] !== d[2]) begin
                bad++; $display("FAIL bp_order: got %h,%h want %h,%h", got[0][31:0], got[1][31:0], d[1][31:0], d[2][31:0]);
            end
        end
    endtask

    task automatic drain(input string tag);
        @(negedge clock);
        rd_valid = 1'b0; wr_valid = 1'b0; resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (resp_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL %s_extra: unexpected response %h", tag, resp_data[63:0]);
                end else if (resp_data !== exp_q[0]) begin
                    bad++; $display("FAIL %s_data: got %h want %h", tag, resp_data[63:0], exp_q[0][63:0]);
                end
            end
            @(negedge clock);
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL %s_missing: %0d responses outstanding want 0", tag, exp_q.size()); end
    endtask

    task automatic test_round_robin();
        logic [1:0] g;
        do_reset();
        resp_ready = 1'b1;
        @(negedge clock);
        rd_valid = 1'b1; rd_addr = 'h005;
        wr_valid = 1'b1; wr_addr = 'h020; wr_mask = 16'(($urandom)); wr_data = rand_row();
        for (int i = 0; i < 4; i++) begin
            #1;
            g = {sram_en, sram_wmode};
            total++;
            if (g !== ((i % 2 == 0) ? 2'b10 : 2'b11)) begin
                bad++; $display("FAIL rr_grant%0d: en/wmode got %b want %b", i, g, (i % 2 == 0) ? 2'b10 : 2'b11);
            end
            @(negedge clock);
        end
        drain("rr");
    endtask

    task automatic test_random();
        bit            prev_stall;
        logic [DW-1:0] prev_data;
        for (int i = 0; i < 16; i++) wr_one(AW'(10'h100 + i), 16'hFFFF, rand_row());
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            rd_valid   = 1'($urandom_range(0, 1));
            rd_addr    = AW'(10'h100 + $urandom_range(0, 15));
            wr_valid   = 1'($urandom_range(0, 1));
            wr_addr    = AW'(10'h100 + $urandom_range(0, 15));
            wr_mask    = 16'($urandom);
            wr_data    = rand_row();
            resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (resp_valid) begin
                total++;
                if (exp_q.size() == 0 || resp_data !== exp_q[0]) begin
                    bad++; $display("FAIL rnd_data c%0d: got %h queued %0d", c, resp_data[63:0], exp_q.size());
                end
            end
            if (prev_stall) begin
                total++;
                if (resp_valid !== 1'b1 || resp_data !== prev_data) begin
                    bad++; $display("FAIL rnd_stable c%0d: valid %b data %h want 1 %h", c, resp_valid, resp_data[63:0], prev_data[63:0]);
                end
            end
            if (rd_ready) begin
                total++;
                if (exp_q.size() >= 2) begin bad++; $display("FAIL rnd_rd_credit c%0d: rd_ready 1 with %0d outstanding want <2", c, exp_q.size()); end
            end
            if (rd_valid && wr_valid) begin
                total++;
                if (rd_ready === wr_ready) begin bad++; $display("FAIL rnd_one_grant c%0d: rd_ready %b wr_ready %b want exactly one", c, rd_ready, wr_ready); end
            end
            prev_stall = resp_valid && !resp_ready;
            prev_data  = resp_data;
        end
        drain("rnd");
    endtask

    task automatic test_reset_flush();
        int seen;
        int lim;
        @(negedge clock);
        resp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 'h100;
        #1;
        total++;
        if (rd_ready !== 1'b1) begin bad++; $display("FAIL fl_rd0: rd_ready got %b want 1", rd_ready); end
        @(negedge clock);
        rd_addr = 'h101;
        #1;
        total++;
        if (rd_ready !== 1'b1) begin bad++; $display("FAIL fl_rd1: rd_ready got %b want 1", rd_ready); end
        @(negedge clock);
        rd_valid = 1'b0; reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0; resp_ready = 1'b1;
`ifdef SRAM_RW_CTRL_INIT_EN
        lim = 1060;
`else
        lim = 30;
`endif
        seen = 0;
        for (int i = 0; i < lim; i++) begin
            #1;
            if (resp_valid) seen++;
            @(negedge clock);
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL fl_stale_resp: resp_valid high %0d cycles want 0", seen); end
    endtask

`ifdef SRAM_RW_CTRL_INIT_EN
    task automatic test_init();
        int  n;
        int  errs;
        bit  hit;
        @(negedge clock);
        reset = 1'b1; rd_valid = 1'b0; wr_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        errs = 0;
        for (n = 0; n < 1100; n++) begin
            #1;
            if (init_done) break;
            if (!(sram_en === 1'b1 && sram_wmode === 1'b1 && sram_addr === AW'(n) &&
                  sram_wmask === '1 && sram_wdata === '0)) errs++;
            @(negedge clock);
        end
        total += 2;
        if (n != 1024) begin bad++; $display("FAIL init_len: init_done after %0d cycles want 1024", n); end
        if (errs != 0) begin bad++; $display("FAIL init_cmds: %0d bad sweep cycles want 0", errs); end
        for (int a = 1020; a < 1024; a++) sram_mem[a] = rand_row();
        total++;
        wr_one('h3FE, 16'h0000, '1);
        @(negedge clock);
        rd_valid = 1'b1; rd_addr = 'h3FF;
        @(negedge clock);
        rd_valid = 1'b0;
        @(negedge clock);
        #1;
        total++;
        if (!(resp_valid === 1'b1 && resp_data === '0 && exp_q.size() == 1)) begin
            bad++; $display("FAIL init_rd_3ff: valid %b data %h want 1 0", resp_valid, resp_data[63:0]);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (sram_addr === 10'd200) begin hit = 1'b1; break; end
            @(negedge clock);
        end
        total++;
        if (!hit) begin bad++; $display("FAIL init_reach200: sweep never at 200 got %h", sram_addr); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++;
        if (!(sram_en === 1'b1 && sram_addr === '0 && init_done === 1'b0)) begin
            bad++; $display("FAIL init_restart: en %b addr %h done %b want 1 000 0", sram_en, sram_addr, init_done);
        end
        wait_init(n);
        total++;
        if (n != 1024) begin bad++; $display("FAIL init_restart_len: got %0d cycles want 1024", n); end
    endtask
`endif

    initial begin
        #700000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; rd_valid = 1'b0; rd_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;
        resp_ready = 1'b0; sram_rdata = '0;
        for (int a = 0; a < 1024; a++) begin
            sram_mem[a] = rand_row();
            mdl_mem[a]  = '0;
        end
        test_reset();
        test_write_read();
        test_mask();
        test_backpressure();
        test_round_robin();
        test_random();
        test_reset_flush();
`ifdef SRAM_RW_CTRL_INIT_EN
        test_init();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
